// File: rtl/lane_scheduler.sv
// lane_scheduler
//
// Sequences the car-lane LED rows for Frogger. A free-running divider produces a
// base tick; each row owns a counter whose period shrinks as the level rises, and
// every wrap of that counter yields a one-cycle step pulse for the row. A four-state
// round FSM (wait/load/run/dead) freezes the car cells, reloads their patterns and
// tracks the difficulty level.
//
// Ports:
//   clk          in   1     system clock
//   reset        in   1     asynchronous, active-high reset
//   start        in   1     one-cycle player start/restart pulse
//   hit          in   1     frog collided with a lit car (level-sensitive)
//   win          in   1     frog reached the far bank (level-sensitive)
//   step         out  ROWS  one-cycle advance enable per row
//   movingRight  out  ROWS  per-row direction (constant DIR_MASK)
//   needReset    out  1     freeze all car cells
//   resetRound   out  1     one-cycle pattern-reload pulse
//   level        out  3     current difficulty level
//   gameOver     out  1     high while the round is dead
//
// All outputs are registered: each flop is loaded from the value the output must
// hold in the state being entered, so outputs change on the same edge as the state.

module lane_scheduler #(
    parameter int unsigned     ROWS        = 8,
    parameter int unsigned     TICK_DIV    = 50,
    parameter int unsigned     BASE_PERIOD = 8,
    parameter int unsigned     MAX_LEVEL   = 7,
    parameter logic [ROWS-1:0] DIR_MASK    = ROWS'(8'hAA)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            hit,
    input  logic            win,
    output logic [ROWS-1:0] step,
    output logic [ROWS-1:0] movingRight,
    output logic            needReset,
    output logic            resetRound,
    output logic [2:0]      level,
    output logic            gameOver
);

    localparam int unsigned     DivW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast  = DivW'(TICK_DIV - 1);
    localparam logic [2:0]      MaxLevel = 3'(MAX_LEVEL);

    typedef enum logic [1:0] {
        StWait,
        StLoad,
        StRun,
        StDead
    } state_e;

    // Row period in ticks: BASE_PERIOD + (row mod 3) - level, floored at 1 and held
    // inside the 4-bit counter range.
    function automatic logic [3:0] row_period(input int row, input logic [2:0] lvl);
        int p;
        p = int'(BASE_PERIOD) + (row % 3) - int'(lvl);
        if (p < 1) begin
            p = 1;
        end
        if (p > 15) begin
            p = 15;
        end
        return 4'(p);
    endfunction

    // ------------------------------------------------------------------------
    // Base tick divider, free running in every state
    // ------------------------------------------------------------------------
    logic [DivW-1:0] div_q, div_d;
    logic            tick;

    assign tick = (div_q == DivLast);

    always_comb begin
        div_d = div_q + DivW'(1);
        if (tick) begin
            div_d = '0;
        end
    end

    // ------------------------------------------------------------------------
    // Round FSM and level
    // ------------------------------------------------------------------------
    state_e     state_q, state_d;
    logic [2:0] level_q, level_d;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        case (state_q)
            StWait: begin
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                state_d = StRun;
            end
            StRun: begin
                // A collision outranks a simultaneous win.
                if (hit) begin
                    state_d = StDead;
                end else if (win) begin
                    state_d = StLoad;
                    if (level_q < MaxLevel) begin
                        level_d = level_q + 3'd1;
                    end
                end
            end
            StDead: begin
                if (start) begin
                    state_d = StLoad;
                    level_d = '0;
                end
            end
            default: begin
                state_d = StWait;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Per-row step counters
    // ------------------------------------------------------------------------
    logic [ROWS-1:0][3:0] cnt_q, cnt_d;
    logic [ROWS-1:0][3:0] period;
    logic [ROWS-1:0]      step_q, step_d;
    logic                 run_hold;

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            period[r] = row_period(r, level_q);
        end
    end

    // Counting requires staying in RUN across the edge: a hit or win seen in the same
    // cycle as a wrap drops the pulse that would otherwise appear next cycle.
    assign run_hold = (state_q == StRun) && (state_d == StRun);

    always_comb begin
        cnt_d  = cnt_q;
        step_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (state_q == StLoad) begin
                cnt_d[r] = '0;
            end else if (run_hold && tick) begin
                // >= guards against a count left above a freshly shortened period.
                if (cnt_q[r] >= period[r] - 4'd1) begin
                    cnt_d[r]  = '0;
                    step_d[r] = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + 4'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered round outputs, decoded from the state being entered
    // ------------------------------------------------------------------------
    logic need_reset_q, need_reset_d;
    logic reset_round_q, reset_round_d;
    logic game_over_q, game_over_d;

    always_comb begin
        need_reset_d  = (state_d == StWait) || (state_d == StDead);
        reset_round_d = (state_d == StLoad);
        game_over_d   = (state_d == StDead);
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            state_q       <= StWait;
            level_q       <= '0;
            cnt_q         <= '0;
            step_q        <= '0;
            need_reset_q  <= 1'b1;
            reset_round_q <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            div_q         <= div_d;
            state_q       <= state_d;
            level_q       <= level_d;
            cnt_q         <= cnt_d;
            step_q        <= step_d;
            need_reset_q  <= need_reset_d;
            reset_round_q <= reset_round_d;
            game_over_q   <= game_over_d;
        end
    end

    assign step        = step_q;
    assign movingRight = DIR_MASK;
    assign needReset   = need_reset_q;
    assign resetRound  = reset_round_q;
    assign level       = level_q;
    assign gameOver    = game_over_q;

endmodule
